// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if
//   Groups the PS/2 line inputs and the key-event outputs of the keyboard
//   front end so the decoder and whatever drives the keyboard lines share one
//   bundle.
// Signals
//   kb_clk           PS/2 clock line, asynchronous to the system clock
//   kb_data          PS/2 data line, asynchronous to the system clock
//   binary_val[3:0]  key value: 0..9 digit, 4'hE backspace
//   valid_scan_code  one-cycle strobe, binary_val valid in the same cycle
//   enter_key        one-cycle strobe when Enter is pressed
//   frame_err        one-cycle strobe on a start, parity or stop error
// Modports
//   master  keyboard side: drives the PS/2 lines, observes key events
//   slave   decoder side: receives the PS/2 lines, produces key events
interface ps2_key_decoder_if;
  logic       kb_clk;
  logic       kb_data;
  logic [3:0] binary_val;
  logic       valid_scan_code;
  logic       enter_key;
  logic       frame_err;

  modport master (
    output kb_clk, kb_data,
    input  binary_val, valid_scan_code, enter_key, frame_err
  );

  modport slave (
    input  kb_clk, kb_data,
    output binary_val, valid_scan_code, enter_key, frame_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   PS/2 keyboard front end for the calculator datapath. Receives 11-bit
//   PS/2 frames, checks start/parity/stop, follows make/break/extended
//   scan-code sequences and emits one-cycle key events for digits,
//   backspace and Enter.
// Ports
//   clk  system clock
//   rst  reset, asynchronous assert, active-low
//   kb   ps2_key_decoder_if.slave: kb_clk/kb_data in; binary_val,
//        valid_scan_code, enter_key, frame_err out
// Parameters
//   FILTER_LEN   identical synced kb_clk samples needed to accept a level change
//   TIMEOUT_CYC  clk cycles without a kb_clk fall before a partial frame is dropped
module ps2_key_decoder #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input logic              clk,
  input logic              rst,
  ps2_key_decoder_if.slave kb
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic {F_IDLE, F_RECV} frameState_t;
  typedef enum logic [1:0] {S_NORMAL, S_EXT, S_BREAK, S_EXT_BREAK} seqState_t;

  logic rstMeta_q, rstSync_q;
  logic clkMeta_q, clkSync_q, dataMeta_q, dataSync_q;
  logic clkFilt_q, clkFilt_d;
  logic [FCW-1:0] filtCnt_q, filtCnt_d;
  logic fall;

  frameState_t frameState_q, frameState_d;
  logic [3:0]     bitCnt_q, bitCnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           parity_q, parity_d;
  logic [WDW-1:0] wdCnt_q, wdCnt_d;
  logic           codeRdy_q, codeRdy_d;
  logic [7:0]     code_q, code_d;
  logic           frameErr_q, frameErr_d;

  seqState_t seqState_q, seqState_d;
  logic [3:0] binVal_q, binVal_d;
  logic       valid_q, valid_d;
  logic       enter_q, enter_d;
  logic       mapHit;
  logic [3:0] mapVal;

  // Reset synchronizer: internal logic is cleared the moment rst drops, but
  // leaves reset only on a clock edge so no flop sees a release mid-cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstMeta_q <= 1'b0;
      rstSync_q <= 1'b0;
    end else begin
      rstMeta_q <= 1'b1;
      rstSync_q <= rstMeta_q;
    end
  end

  // Line synchronizers and the kb_clk glitch filter state. The lines idle
  // high, so everything here resets to 1 to avoid a fake fall after reset.
  always_ff @(posedge clk or negedge rstSync_q) begin
    if (!rstSync_q) begin
      clkMeta_q  <= 1'b1;
      clkSync_q  <= 1'b1;
      dataMeta_q <= 1'b1;
      dataSync_q <= 1'b1;
      clkFilt_q  <= 1'b1;
      filtCnt_q  <= '0;
    end else begin
      clkMeta_q  <= kb.kb_clk;
      clkSync_q  <= clkMeta_q;
      dataMeta_q <= kb.kb_data;
      dataSync_q <= dataMeta_q;
      clkFilt_q  <= clkFilt_d;
      filtCnt_q  <= filtCnt_d;
    end
  end

  // The filtered clock follows the synced clock only once FILTER_LEN samples
  // in a row disagree with it; any agreeing sample restarts the count.
  // fall marks the cycle in which the filtered clock is about to go 1->0,
  // and the synced data of that same cycle is the bit being received.
  always_comb begin
    clkFilt_d = clkFilt_q;
    filtCnt_d = '0;
    if (clkSync_q != clkFilt_q) begin
      if (filtCnt_q == FCW'(FILTER_LEN - 1)) begin
        clkFilt_d = clkSync_q;
      end else begin
        filtCnt_d = filtCnt_q + FCW'(1);
      end
    end
    fall = clkFilt_q & ~clkFilt_d;
  end

  // Frame FSM and sequence FSM state registers, plus registered outputs.
  always_ff @(posedge clk or negedge rstSync_q) begin
    if (!rstSync_q) begin
      frameState_q <= F_IDLE;
      bitCnt_q     <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      wdCnt_q      <= '0;
      codeRdy_q    <= 1'b0;
      code_q       <= '0;
      frameErr_q   <= 1'b0;
      seqState_q   <= S_NORMAL;
      binVal_q     <= '0;
      valid_q      <= 1'b0;
      enter_q      <= 1'b0;
    end else begin
      frameState_q <= frameState_d;
      bitCnt_q     <= bitCnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      wdCnt_q      <= wdCnt_d;
      codeRdy_q    <= codeRdy_d;
      code_q       <= code_d;
      frameErr_q   <= frameErr_d;
      seqState_q   <= seqState_d;
      binVal_q     <= binVal_d;
      valid_q      <= valid_d;
      enter_q      <= enter_d;
    end
  end

  // Frame FSM: start bit, 8 data bits LSB first, odd parity, stop bit.
  // The watchdog only runs while a frame is in progress; when it expires the
  // partial frame is silently abandoned so a lost edge cannot misalign the
  // next frame.
  always_comb begin
    frameState_d = frameState_q;
    bitCnt_d     = bitCnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    code_d       = code_q;
    codeRdy_d    = 1'b0;
    frameErr_d   = 1'b0;
    wdCnt_d      = (frameState_q == F_RECV) ? wdCnt_q + WDW'(1) : '0;
    case (frameState_q)
      F_IDLE: begin
        if (fall) begin
          if (!dataSync_q) begin
            frameState_d = F_RECV;
            bitCnt_d     = 4'd1;
          end else begin
            frameErr_d = 1'b1;
          end
        end
      end
      F_RECV: begin
        if (fall) begin
          wdCnt_d  = '0;
          bitCnt_d = bitCnt_q + 4'd1;
          if (bitCnt_q <= 4'd8) begin
            shift_d = {dataSync_q, shift_q[7:1]};
          end else if (bitCnt_q == 4'd9) begin
            parity_d = dataSync_q;
          end else begin
            frameState_d = F_IDLE;
            if (dataSync_q && ((^shift_q) ^ parity_q)) begin
              codeRdy_d = 1'b1;
              code_d    = shift_q;
            end else begin
              frameErr_d = 1'b1;
            end
          end
        end else if (wdCnt_q == WDW'(TIMEOUT_CYC - 1)) begin
          frameState_d = F_IDLE;
        end
      end
      default: frameState_d = F_IDLE;
    endcase
  end

  // Scan-code set 2 lookup for the non-extended digit and backspace keys,
  // main row and keypad.
  always_comb begin
    mapHit = 1'b1;
    mapVal = 4'd0;
    case (code_q)
      8'h45, 8'h70: mapVal = 4'd0;
      8'h16, 8'h69: mapVal = 4'd1;
      8'h1E, 8'h72: mapVal = 4'd2;
      8'h26, 8'h7A: mapVal = 4'd3;
      8'h25, 8'h6B: mapVal = 4'd4;
      8'h2E, 8'h73: mapVal = 4'd5;
      8'h36, 8'h74: mapVal = 4'd6;
      8'h3D, 8'h6C: mapVal = 4'd7;
      8'h3E, 8'h75: mapVal = 4'd8;
      8'h46, 8'h7D: mapVal = 4'd9;
      8'h66:        mapVal = 4'hE;
      default:      mapHit = 1'b0;
    endcase
  end

  // Sequence FSM: F0 means the next code is a release and is swallowed; E0
  // prefixes an extended key, of which only keypad Enter is of interest.
  // binary_val keeps its last value between events.
  always_comb begin
    seqState_d = seqState_q;
    binVal_d   = binVal_q;
    valid_d    = 1'b0;
    enter_d    = 1'b0;
    if (codeRdy_q) begin
      case (seqState_q)
        S_NORMAL: begin
          if (code_q == 8'hF0) begin
            seqState_d = S_BREAK;
          end else if (code_q == 8'hE0) begin
            seqState_d = S_EXT;
          end else if (code_q == 8'h5A) begin
            enter_d = 1'b1;
          end else if (mapHit) begin
            valid_d  = 1'b1;
            binVal_d = mapVal;
          end
        end
        S_EXT: begin
          seqState_d = S_NORMAL;
          if (code_q == 8'hF0) begin
            seqState_d = S_EXT_BREAK;
          end else if (code_q == 8'h5A) begin
            enter_d = 1'b1;
          end
        end
        default: seqState_d = S_NORMAL;
      endcase
    end
  end

  assign kb.binary_val      = binVal_q;
  assign kb.valid_scan_code = valid_q;
  assign kb.enter_key       = enter_q;
  assign kb.frame_err       = frameErr_q;

endmodule
